// File: rtl/axi_sram_slave_p.sv
// rtl/axi_sram_slave_p.sv - AXI4 slave in front of a single-port one-cycle-latency SRAM bank
module axi_sram_slave_p #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 16384
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ID_W-1:0]          AWID,
    input  logic [ADDR_W-1:0]        AWADDR,
    input  logic [LEN_W-1:0]         AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_W-1:0]        WDATA,
    input  logic [DATA_W/8-1:0]      WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [ID_W-1:0]          BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ID_W-1:0]          ARID,
    input  logic [ADDR_W-1:0]        ARADDR,
    input  logic [LEN_W-1:0]         ARLEN,
    input  logic [2:0]               ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [ID_W-1:0]          RID,
    output logic [DATA_W-1:0]        RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic                     mem_CEB,
    output logic                     mem_WEB,
    output logic [$clog2(DEPTH)-1:0] mem_A,
    output logic [DATA_W-1:0]        mem_D,
    output logic [DATA_W-1:0]        mem_BWEB,
    input  logic [DATA_W-1:0]        mem_Q
);

    localparam int B  = DATA_W / 8;
    localparam int BL = $clog2(B);
    localparam int WA = $clog2(DEPTH);
    localparam int MA = BL + WA;

    localparam logic [2:0]     SIZE_OK   = 3'(BL);
    localparam logic [WA-1:0]  WORD_ONE  = WA'(1);
    localparam logic [LEN_W:0] CNT_ONE   = (LEN_W+1)'(1);
    localparam logic [1:0]     BURST_FIXED = 2'b00;
    localparam logic [1:0]     BURST_INCR  = 2'b01;
    localparam logic [1:0]     BURST_WRAP  = 2'b10;
    localparam logic [1:0]     BURST_RSVD  = 2'b11;
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_WRESP,
        S_RD
    } state_t;

    state_t            state;
    logic              last_wr;
    logic              err_r;
    logic [ID_W-1:0]   id_r;
    logic [WA-1:0]     word_r;
    logic [1:0]        burst_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W:0]    issue_cnt;
    logic [LEN_W:0]    beat_cnt;

    logic              inflight;
    logic [1:0]        skid_cnt;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [DATA_W-1:0] skid_data [2];

    logic              idle;
    logic              grant_rd;
    logic              grant_wr;
    logic              ar_hs;
    logic              aw_hs;
    logic [ID_W-1:0]   ax_id;
    logic [ADDR_W-1:0] ax_addr;
    logic [LEN_W-1:0]  ax_len;
    logic [2:0]        ax_size;
    logic [1:0]        ax_burst;
    logic              ax_err;

    logic [WA-1:0]     wrap_mask;
    logic [WA-1:0]     word_inc;
    logic [WA-1:0]     word_next;

    logic              w_hs;
    logic              rd_issue;
    logic              wr_acc;
    logic              rd_acc;
    logic              r_valid;
    logic              r_pop;
    logic              buf_push;
    logic              buf_pop;
    logic [DATA_W-1:0] q_data;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] strb_bits;

    // Round-robin grant in IDLE; a tie goes to the channel not served last
    always_comb begin
        idle     = (state == S_IDLE);
        grant_rd = ARVALID & (~AWVALID | last_wr);
        grant_wr = AWVALID & ~grant_rd;
        ar_hs    = idle & grant_rd;
        aw_hs    = idle & grant_wr;
        ARREADY  = ar_hs;
        AWREADY  = aw_hs;
        ax_id    = grant_rd ? ARID    : AWID;
        ax_addr  = grant_rd ? ARADDR  : AWADDR;
        ax_len   = grant_rd ? ARLEN   : AWLEN;
        ax_size  = grant_rd ? ARSIZE  : AWSIZE;
        ax_burst = grant_rd ? ARBURST : AWBURST;
    end

    // Legality of the granted request; any violation turns the whole burst into SLVERR
    always_comb begin
        ax_err = 1'b0;
        if (ax_addr[ADDR_W-1:MA] != '0) ax_err = 1'b1;
        if (ax_addr[BL-1:0] != '0)      ax_err = 1'b1;
        if (ax_size != SIZE_OK)         ax_err = 1'b1;
        if (ax_burst == BURST_RSVD)     ax_err = 1'b1;
        if ((ax_burst == BURST_WRAP) &&
            !((ax_len == LEN_W'(1)) || (ax_len == LEN_W'(3)) ||
              (ax_len == LEN_W'(7)) || (ax_len == LEN_W'(15))))
            ax_err = 1'b1;
    end

    // Next word address; WRAP lengths are 2^n-1 so the length doubles as the window mask
    always_comb begin
        wrap_mask = {{(WA-LEN_W){1'b0}}, len_r};
        word_inc  = word_r + WORD_ONE;
        case (burst_r)
            BURST_FIXED: word_next = word_r;
            BURST_WRAP:  word_next = (word_r & ~wrap_mask) | (word_inc & wrap_mask);
            BURST_INCR:  word_next = word_inc;
            default:     word_next = word_inc;
        endcase
    end

    // Beat handshakes, read issue throttle and the read return path
    always_comb begin
        w_hs      = (state == S_WR) & WVALID;
        rd_issue  = (state == S_RD) && (issue_cnt != '0) &&
                    ((skid_cnt + {1'b0, inflight}) < 2'd2);
        wr_acc    = w_hs & ~err_r;
        rd_acc    = rd_issue & ~err_r;
        q_data    = err_r ? '0 : mem_Q;
        r_valid   = (skid_cnt != 2'd0) | inflight;
        head_data = (skid_cnt != 2'd0) ? skid_data[rd_ptr] : q_data;
        r_pop     = r_valid & RREADY;
        buf_push  = inflight & ~((skid_cnt == 2'd0) & r_pop);
        buf_pop   = r_pop & (skid_cnt != 2'd0);
    end

    // Byte strobes expanded to the active-low bit-write mask
    always_comb begin
        strb_bits = '0;
        for (int i = 0; i < B; i++) begin
            strb_bits[i*8 +: 8] = {8{WSTRB[i]}};
        end
    end

    // SRAM pins and AXI response outputs
    always_comb begin
        mem_CEB  = ~(wr_acc | rd_acc);
        mem_WEB  = ~wr_acc;
        mem_A    = (wr_acc | rd_acc) ? word_r : '0;
        mem_D    = wr_acc ? WDATA : '0;
        mem_BWEB = wr_acc ? ~strb_bits : '1;
        WREADY   = (state == S_WR);
        BVALID   = (state == S_WRESP);
        BRESP    = (BVALID & err_r) ? RESP_SLVERR : RESP_OKAY;
        BID      = id_r;
        RVALID   = r_valid;
        RDATA    = r_valid ? head_data : '0;
        RRESP    = (r_valid & err_r) ? RESP_SLVERR : RESP_OKAY;
        RLAST    = r_valid & (beat_cnt == CNT_ONE);
        RID      = id_r;
    end

    // Transaction FSM: captures the request, walks addresses and counts beats
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= S_IDLE;
            last_wr   <= 1'b1;
            err_r     <= 1'b0;
            id_r      <= '0;
            word_r    <= '0;
            burst_r   <= '0;
            len_r     <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ar_hs || aw_hs) begin
                        id_r    <= ax_id;
                        word_r  <= ax_addr[MA-1:BL];
                        burst_r <= ax_burst;
                        len_r   <= ax_len;
                        err_r   <= ax_err;
                        last_wr <= aw_hs;
                        if (ar_hs) begin
                            issue_cnt <= {1'b0, ax_len} + CNT_ONE;
                            beat_cnt  <= {1'b0, ax_len} + CNT_ONE;
                            state     <= S_RD;
                        end else begin
                            state     <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (w_hs) begin
                        word_r <= word_next;
                        if (WLAST) state <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (BREADY) state <= S_IDLE;
                end
                S_RD: begin
                    if (rd_issue) begin
                        issue_cnt <= issue_cnt - CNT_ONE;
                        word_r    <= word_next;
                    end
                    if (r_pop) begin
                        beat_cnt <= beat_cnt - CNT_ONE;
                        if (beat_cnt == CNT_ONE) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-entry skid buffer; SRAM data bypasses it when empty and the master is ready
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            inflight     <= 1'b0;
            skid_cnt     <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            skid_data[0] <= '0;
            skid_data[1] <= '0;
        end else begin
            inflight <= rd_issue;
            if (buf_push) begin
                skid_data[wr_ptr] <= q_data;
                wr_ptr            <= ~wr_ptr;
            end
            if (buf_pop) rd_ptr <= ~rd_ptr;
            case ({buf_push, buf_pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave_p.sv
// tb/tb_axi_sram_slave_p.sv - directed self-checking bench for axi_sram_slave_p
module tb_axi_sram_slave_p;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_CEB;
    logic        mem_WEB;
    logic [13:0] mem_A;
    logic [31:0] mem_D;
    logic [31:0] mem_BWEB;
    logic [31:0] mem_Q = '0;

    axi_sram_slave_p dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_CEB(mem_CEB), .mem_WEB(mem_WEB), .mem_A(mem_A), .mem_D(mem_D),
        .mem_BWEB(mem_BWEB), .mem_Q(mem_Q)
    );

    always #5 ACLK = ~ACLK;

    logic [31:0] sram [0:16383];

    always @(posedge ACLK) begin
        if (!mem_CEB) begin
            if (!mem_WEB) sram[mem_A] <= (sram[mem_A] & mem_BWEB) | (mem_D & ~mem_BWEB);
            else          mem_Q <= sram[mem_A];
        end
    end

    int checks = 0;
    int errors = 0;
    int timeouts = 0;

    logic [31:0] wd [0:15];
    logic [3:0]  ws [0:15];
    logic [1:0]  bq_resp;
    logic [7:0]  bq_id;
    logic        bq_wrdy_first;
    logic        bq_bvalid_first;
    int          bq_wacc;

    logic [31:0] rq_data [0:15];
    logic [1:0]  rq_resp [0:15];
    logic        rq_last [0:15];
    logic [7:0]  rq_id;
    int          rq_n, rq_first, rq_maxout, rq_issued, rq_stab;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] id);
        int g;
        bq_wacc = 0;
        @(posedge ACLK); #1;
        AWVALID = 1; AWADDR = addr; AWLEN = 4'(len); AWSIZE = size; AWBURST = burst; AWID = id;
        @(negedge ACLK);
        g = 0;
        while (!AWREADY && g < 50) begin @(posedge ACLK); #1; @(negedge ACLK); g++; end
        if (!AWREADY) timeouts++;
        @(posedge ACLK); #1;
        AWVALID = 0;
        for (int i = 0; i <= len; i++) begin
            WVALID = 1; WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == len);
            @(negedge ACLK);
            if (i == 0) bq_wrdy_first = WREADY;
            g = 0;
            while (!WREADY && g < 50) begin @(posedge ACLK); #1; @(negedge ACLK); g++; end
            if (!WREADY) timeouts++;
            if (!mem_CEB && !mem_WEB) bq_wacc++;
            @(posedge ACLK); #1;
        end
        WVALID = 0; WLAST = 0; BREADY = 1;
        @(negedge ACLK);
        bq_bvalid_first = BVALID;
        g = 0;
        while (!BVALID && g < 50) begin @(posedge ACLK); #1; @(negedge ACLK); g++; end
        if (!BVALID) timeouts++;
        bq_resp = BRESP; bq_id = BID;
        @(posedge ACLK); #1;
        BREADY = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] id, input int mode);
        int g, cyc, pidx;
        logic hold_v, hold_l;
        logic [31:0] hold_d;
        rq_n = 0; rq_first = -1; rq_maxout = 0; rq_issued = 0; rq_stab = 0;
        hold_v = 0; hold_l = 0; hold_d = '0;
        @(posedge ACLK); #1;
        ARVALID = 1; ARADDR = addr; ARLEN = 4'(len); ARSIZE = size; ARBURST = burst; ARID = id;
        @(negedge ACLK);
        g = 0;
        while (!ARREADY && g < 50) begin @(posedge ACLK); #1; @(negedge ACLK); g++; end
        if (!ARREADY) timeouts++;
        @(posedge ACLK); #1;
        ARVALID = 0;
        cyc = 0; pidx = 0; g = 0;
        while (rq_n <= len && g < 200) begin
            cyc++; g++;
            RREADY = (mode == 0) ? 1'b1 : ((pidx % 3) == 0);
            pidx++;
            @(negedge ACLK);
            if (!mem_CEB && mem_WEB) rq_issued++;
            if (RVALID && rq_first < 0) rq_first = cyc;
            if (hold_v && (!RVALID || RDATA !== hold_d || RLAST !== hold_l)) rq_stab++;
            hold_v = RVALID && !RREADY; hold_d = RDATA; hold_l = RLAST;
            if (RVALID && RREADY) begin
                rq_data[rq_n] = RDATA; rq_resp[rq_n] = RRESP; rq_last[rq_n] = RLAST; rq_id = RID;
                rq_n++;
            end
            if (rq_issued - rq_n > rq_maxout) rq_maxout = rq_issued - rq_n;
            @(posedge ACLK); #1;
        end
        if (rq_n <= len) timeouts++;
        RREADY = 0;
    endtask

    int g;

    initial begin
        for (int i = 0; i < 16384; i++) sram[i] = '0;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
        WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
        ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
        #1 ARESET = 1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_readies", {ARREADY, AWREADY, WREADY}, 3'b000);
        chk("rst_valids", {BVALID, RVALID, RLAST}, 3'b000);
        chk("rst_mem_ctl", {mem_CEB, mem_WEB}, 2'b11);
        chk("rst_mem_bweb", mem_BWEB, 32'hFFFF_FFFF);
        chk("rst_mem_a_d", {mem_A, mem_D}, 46'h0);
        chk("rst_resp_ids", {BRESP, RRESP, BID, RID}, 20'h0);
        chk("rst_rdata", RDATA, 32'h0);
        @(posedge ACLK); #1;
        ARESET = 0;

        // simultaneous AR and AW after reset: read wins, write follows
        @(posedge ACLK); #1;
        ARVALID = 1; ARADDR = 0; ARLEN = 0; ARSIZE = 3'd2; ARBURST = 2'b01; ARID = 8'h11;
        AWVALID = 1; AWADDR = 0; AWLEN = 0; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 8'h22;
        @(negedge ACLK);
        chk("arb_ar_first", ARREADY, 1);
        chk("arb_aw_wait", AWREADY, 0);
        @(posedge ACLK); #1;
        ARVALID = 0; RREADY = 1;
        @(negedge ACLK);
        chk("arb_aw_blocked", AWREADY, 0);
        g = 0;
        while (!RVALID && g < 20) begin @(posedge ACLK); #1; @(negedge ACLK); g++; end
        if (!RVALID) timeouts++;
        chk("arb_rid", RID, 8'h11);
        chk("arb_rdata", RDATA, 32'h0);
        chk("arb_rlast", RLAST, 1);
        @(posedge ACLK); #1;
        RREADY = 0;
        @(negedge ACLK);
        g = 0;
        while (!AWREADY && g < 20) begin @(posedge ACLK); #1; @(negedge ACLK); g++; end
        chk("arb_aw_next", AWREADY, 1);
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 1; WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF; WLAST = 1;
        @(negedge ACLK);
        g = 0;
        while (!WREADY && g < 20) begin @(posedge ACLK); #1; @(negedge ACLK); g++; end
        if (!WREADY) timeouts++;
        @(posedge ACLK); #1;
        WVALID = 0; WLAST = 0; BREADY = 1;
        @(negedge ACLK);
        g = 0;
        while (!BVALID && g < 20) begin @(posedge ACLK); #1; @(negedge ACLK); g++; end
        if (!BVALID) timeouts++;
        chk("arb_bresp", BRESP, 2'b00);
        chk("arb_bid", BID, 8'h22);
        @(posedge ACLK); #1;
        BREADY = 0;

        // INCR write then read of 0x100..0x10C
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        do_write(32'h100, 3, 3'd2, 2'b01, 8'h05);
        chk("incr_bresp", bq_resp, 2'b00);
        chk("incr_bid", bq_id, 8'h05);
        chk("incr_wready_t1", bq_wrdy_first, 1);
        chk("incr_bvalid_w1", bq_bvalid_first, 1);
        do_read(32'h100, 3, 3'd2, 2'b01, 8'h06, 0);
        chk("incr_rd0", rq_data[0], 32'hA0);
        chk("incr_rd1", rq_data[1], 32'hA1);
        chk("incr_rd2", rq_data[2], 32'hA2);
        chk("incr_rd3", rq_data[3], 32'hA3);
        chk("incr_rlast", {rq_last[3], rq_last[2], rq_last[1], rq_last[0]}, 4'b1000);
        chk("incr_rvalid_t2", rq_first, 2);
        chk("incr_rresp", {rq_resp[0], rq_resp[3]}, 4'b0000);
        chk("incr_rid", rq_id, 8'h06);

        // strobe write over 0xFFFFFFFF at word 0
        wd[0] = 32'h1234_5678; ws[0] = 4'b0101;
        do_write(32'h0, 0, 3'd2, 2'b01, 8'h07);
        chk("strb_bresp", bq_resp, 2'b00);
        do_read(32'h0, 0, 3'd2, 2'b01, 8'h07, 0);
        chk("strb_rdata", rq_data[0], 32'hFF34_FF78);

        // WRAP read starting mid-window
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h10, 3, 3'd2, 2'b01, 8'h08);
        do_read(32'h18, 3, 3'd2, 2'b10, 8'h09, 0);
        chk("wrap_rd0", rq_data[0], 32'd3);
        chk("wrap_rd1", rq_data[1], 32'd4);
        chk("wrap_rd2", rq_data[2], 32'd1);
        chk("wrap_rd3", rq_data[3], 32'd2);
        chk("wrap_rlast", rq_last[3], 1);

        // 8-beat read under RREADY back-pressure
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; end
        do_write(32'h200, 7, 3'd2, 2'b01, 8'h0A);
        do_read(32'h200, 7, 3'd2, 2'b01, 8'h0B, 1);
        chk("bp_beats", rq_n, 8);
        for (int i = 0; i < 8; i++) chk("bp_rdata", rq_data[i], 32'hB0 + i);
        chk("bp_rlast", {rq_last[7], rq_last[6]}, 2'b10);
        chk("bp_outstanding_le2", rq_maxout <= 2, 1);
        chk("bp_stable", rq_stab, 0);

        // out-of-range read address
        do_read(32'h0001_0000, 1, 3'd2, 2'b01, 8'h0C, 0);
        chk("err_rd_beats", rq_n, 2);
        chk("err_rd_resp", {rq_resp[0], rq_resp[1]}, 4'b1010);
        chk("err_rd_data", {rq_data[0], rq_data[1]}, 64'h0);
        chk("err_rd_last", {rq_last[1], rq_last[0]}, 2'b10);
        chk("err_rd_no_sram", rq_issued, 0);

        // reserved burst type on read
        do_read(32'h100, 0, 3'd2, 2'b11, 8'h0D, 0);
        chk("err_burst_resp", rq_resp[0], 2'b10);

        // narrow write size is rejected and memory untouched
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(32'h100, 0, 3'd1, 2'b01, 8'h0E);
        chk("err_size_bresp", bq_resp, 2'b10);
        chk("err_size_no_wr", bq_wacc, 0);
        do_read(32'h100, 0, 3'd2, 2'b01, 8'h0E, 0);
        chk("err_size_mem", rq_data[0], 32'hA0);

        // reset asserted during a write data phase
        @(posedge ACLK); #1;
        AWVALID = 1; AWADDR = 32'h300; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 8'h77;
        @(negedge ACLK);
        g = 0;
        while (!AWREADY && g < 20) begin @(posedge ACLK); #1; @(negedge ACLK); g++; end
        if (!AWREADY) timeouts++;
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 1; WDATA = 32'h11; WSTRB = 4'hF; WLAST = 0;
        @(posedge ACLK); #1;
        WDATA = 32'h22;
        @(posedge ACLK); #1;
        WDATA = 32'h33;
        @(negedge ACLK);
        chk("mid_wr_active", {WREADY, mem_CEB}, 2'b10);
        #1 ARESET = 1;
        #1;
        chk("mid_rst_ready", {WREADY, BVALID, AWREADY, RVALID}, 4'b0000);
        chk("mid_rst_mem_ctl", {mem_CEB, mem_WEB}, 2'b11);
        chk("mid_rst_mem_bweb", mem_BWEB, 32'hFFFF_FFFF);
        chk("mid_rst_mem_a_d", {mem_A, mem_D}, 46'h0);
        chk("mid_rst_bid", BID, 8'h0);
        @(posedge ACLK); #1;
        ARESET = 0; WVALID = 0;
        BREADY = 1;
        @(negedge ACLK);
        chk("mid_rst_no_b", {BVALID, WREADY}, 2'b00);
        @(posedge ACLK); #1;
        BREADY = 0;
        wd[0] = 32'h55; ws[0] = 4'hF;
        do_write(32'h300, 0, 3'd2, 2'b01, 8'h78);
        chk("post_rst_bresp", bq_resp, 2'b00);
        chk("post_rst_bid", bq_id, 8'h78);
        do_read(32'h300, 0, 3'd2, 2'b01, 8'h79, 0);
        chk("post_rst_rdata", rq_data[0], 32'h55);

        chk("timeouts", timeouts, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave_p.md
# axi_sram_slave_p

Parametrised AXI4 slave that fronts a single-port, one-cycle-latency SRAM macro and serves one transaction at a time from either the read or the write channel. It is the successor to the fixed 32-bit SRAM wrapper. It adds generic data, address and ID widths, byte-strobe writes, FIXED/INCR/WRAP bursts, round-robin read/write arbitration, a 2-entry read skid buffer that tolerates RREADY back-pressure, and SLVERR responses for illegal requests. It sits behind the AXI interconnect, one instance per SRAM bank.

## Interface
- DATA_W, 32, AXI/SRAM data width; power of two, at least 32
- ADDR_W, 32, AXI address width
- ID_W, 8, AXI ID width (slave side)
- LEN_W, 4, AxLEN width
- DEPTH, 16384, SRAM depth in words; power of two
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  asynchronous, active-high reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  ID_W/ADDR_W/LEN_W/3/2/1  write address; AWREADY  out  1
- WDATA/WSTRB/WLAST/WVALID  in  DATA_W/DATA_W/8/1/1  write data; WREADY  out  1
- BID/BRESP/BVALID  out  ID_W/2/1  write response; BREADY  in  1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  as AW; ARREADY  out  1
- RID/RDATA/RRESP/RLAST/RVALID  out  ID_W/DATA_W/2/1/1  read data; RREADY  in  1
- mem_CEB, mem_WEB  out  1  SRAM chip enable and write enable, both active-low
- mem_A  out  log2(DEPTH)  SRAM word address
- mem_D  out  DATA_W  SRAM write data
- mem_BWEB  out  DATA_W  SRAM bit-write enable, active-low
- mem_Q  in  DATA_W  SRAM read data, valid one cycle after a read with mem_CEB=0

## Operation
- Constants:
  - B = DATA_W/8
  - word index = addr[log2(B)+log2(DEPTH)-1 : log2(B)]
- States and transitions:
  - IDLE -> RD, or IDLE -> WR, on the AR or AW handshake respectively.
  - WR -> WRESP on the WLAST beat handshake.
  - WRESP -> IDLE on B handshake.
  - RD -> IDLE on the RLAST handshake.
- Arbitration (IDLE only): ARREADY/AWREADY are driven combinationally from the grant.
  - If only one valid is present, that channel is granted.
  - If both are present, the channel not served last is granted.
  - After reset, last-served = write, so read wins the first tie.
  - Both readies are 0 outside IDLE.
- Request checks, evaluated at the address handshake. Any failure marks the whole burst as error:
  - address above the word range: addr[ADDR_W-1 : log2(B)+log2(DEPTH)] ≠ 0
  - AxSIZE ≠ log2(B)
  - AxBURST = 2'b11
  - WRAP with AxLEN not in {1,3,7,15}
  - address not B-aligned
- Address generation, per beat:
  - FIXED: the address is held.
  - INCR: the address increases by B and wraps modulo the SRAM size.
  - WRAP: the address increases by B inside the window of (LEN+1)·B bytes aligned to that size; past the top it returns to the window base.
- Write:
  - WREADY = 1 in WR.
  - Each W handshake on a legal burst performs an SRAM write in that same cycle:
    - mem_CEB = 0, mem_WEB = 0
    - mem_BWEB = inverted byte-expanded WSTRB
    - mem_D = WDATA
  - On an error burst, beats are accepted and no SRAM access is made.
  - BRESP = 00 (OKAY) or 10 (SLVERR); BID = the captured AWID.
- Read:
  - A beat counter and an issue counter both start at AxLEN+1.
  - An SRAM read is issued (mem_CEB=0, mem_WEB=1) when:
    - issues remain, and
    - skid occupancy + reads in flight < 2.
  - mem_Q is pushed into the skid buffer the cycle after issue.
  - RVALID = skid buffer not empty; RDATA/RRESP come from its head.
  - RLAST = 1 when the head entry is the final beat.
  - RID = the captured ARID.
  - On an error burst, no SRAM access is made: entries are pushed with RDATA=0 and RRESP=10.
- SRAM is idle when not accessed: mem_CEB=1, mem_WEB=1, mem_BWEB all-ones.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, skid buffer emptied, counters cleared
  - outputs: ready/valid outputs 0 except arbitration-driven ARREADY/AWREADY; BRESP/RRESP/RID/BID/RDATA/RLAST all 0; mem_CEB=1, mem_WEB=1, mem_BWEB all-ones, mem_A=0, mem_D=0
- Reset mid-burst abandons the transaction; no B or R response is produced for it afterwards.
- Read latency:
  - AR handshake at cycle T → first SRAM read at T+1 → RVALID at T+2.
  - With RREADY held high, one beat per cycle thereafter.
- Read under back-pressure: with RREADY low, at most 2 beats are buffered and no data is lost or reordered. RDATA/RLAST/RRESP stay stable while RVALID=1 and RREADY=0.
- Write timing:
  - AW handshake at T → WREADY from T+1.
  - WLAST handshake at W → BVALID at W+1, held until BREADY.
- A new address handshake is possible in the cycle after the state returns to IDLE.
- A WLAST arriving early or late relative to AWLEN is not checked; the burst ends on WLAST.

## Test plan
- INCR write then read, DATA_W=32, AWADDR=0x100, AWLEN=3, data 0xA0..0xA3, WSTRB=0xF → BRESP=00; a read of the same range returns 0xA0..0xA3 with RLAST on beat 3 and RVALID at T+2.
- Strobe write: word 0x0 holds 0xFFFFFFFF; write 0x12345678 with WSTRB=4'b0101 → read returns 0xFF34FF78.
- WRAP read with ARLEN=3, ARADDR=0x18 after preloading 0x10..0x1C with 1..4 → RDATA sequence 3,4,1,2.
- Back-pressure: an 8-beat INCR read with RREADY toggling 1,0,0,1,… → all 8 beats in order, no duplicates, at most 2 SRAM reads outstanding beyond accepted beats.
- Errors: ARADDR = 4·DEPTH with ARLEN=1 → two beats, RRESP=10, RDATA=0, RLAST on the second beat. AWSIZE=1 → BRESP=10 and SRAM contents unchanged.
- Arbitration and reset:
  - AR and AW asserted together after reset → the read is granted first and the write next.
  - ARESET pulsed during a write data phase → all outputs return to reset values immediately; the next AW is accepted normally.
